uart_rx: RTL and testbench

UART receiver, N,8,1, LSB first. It is the receive-side counterpart to the team's uart_tx transmitter and uses the same CLKS_PER_BIT timing convention. It synchronises the asynchronous serial input, qualifies the start bit at mid-bit, samples each data bit at its centre, and checks the stop bit. Good bytes are delivered with a one-clock valid strobe; bad frames are flagged with a one-clock framing-error strobe.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : UART receiver, 8 data bits, no parity, 1 stop bit, LSB first.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Framing_Err
);

  localparam logic [9:0] HALF_C = 10'((CLKS_PER_BIT - 1) / 2);
  localparam logic [9:0] LAST_C = 10'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       dv_q, dv_d;
  logic       act_q, act_d;
  logic       ferr_q, ferr_d;
  logic       sync1_q, rx_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      act_q   <= 1'b0;
      ferr_q  <= 1'b0;
      sync1_q <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      act_q   <= act_d;
      ferr_q  <= ferr_d;
      sync1_q <= i_RX_Serial;
      rx_q    <= sync1_q;
    end
  end

  // Strobes default low, so each lasts exactly the one clock after the stop sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    act_d   = act_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        act_d = 1'b0;
        if (!rx_q) begin
          state_d = S_START;
          act_d   = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q < HALF_C) begin
          cnt_d = cnt_q + 10'd1;
        end else if (!rx_q) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
          act_d   = 1'b0;
        end
      end
      S_DATA: begin
        if (cnt_q < LAST_C) begin
          cnt_d = cnt_q + 10'd1;
        end else begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q < LAST_C) begin
          cnt_d = cnt_q + 10'd1;
        end else begin
          if (rx_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = S_CLEANUP;
        end
      end
      S_CLEANUP: begin
        // Wait for the line to go high so a held break cannot retrigger.
        if (rx_q) begin
          state_d = S_IDLE;
          act_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        act_d   = 1'b0;
      end
    endcase
  end

  assign o_RX_DV          = dv_q;
  assign o_RX_Byte        = byte_q;
  assign o_RX_Active      = act_q;
  assign o_RX_Framing_Err = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Scoreboard bench for uart_rx with a bit-banged transmitter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  typedef struct {
    logic       err;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line = 1'b1;
  logic       dv, act, ferr;
  logic [7:0] rbyte;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic act_seen = 1'b0;
  exp_t q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock         (clk),
    .i_Reset         (rst),
    .i_RX_Serial     (line),
    .o_RX_DV         (dv),
    .o_RX_Byte       (rbyte),
    .o_RX_Active     (act),
    .o_RX_Framing_Err(ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (act) act_seen = 1'b1;
      if (dv || ferr) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", {30'd0, dv, ferr}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("strobe_kind", {30'd0, dv, ferr}, e.err ? 32'd1 : 32'd2);
          check("strobe_cycle", cyc, e.cyc);
          if (!e.err) check("rx_byte", {24'd0, rbyte}, {24'd0, e.b});
        end
      end
    end
  end

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Transmitter model; starts and ends on a negedge. extra_low extends a low stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    exp_t e;
    e.err = ~stop;
    e.b   = b;
    e.cyc = cyc + 1 + (HALF + 3) + 9 * CPB;
    q.push_back(e);
    line = 1'b0;
    idle_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      idle_clks(CPB);
    end
    line = stop;
    idle_clks(CPB * (1 + extra_low));
    line = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 * CPB && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check(name, q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    logic [7:0] vecs [5];
    vecs = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};

    idle_clks(3);
    check("reset_dv", {31'd0, dv}, 0);
    check("reset_byte", {24'd0, rbyte}, 0);
    check("reset_active", {31'd0, act}, 0);
    check("reset_ferr", {31'd0, ferr}, 0);
    rst = 1'b0;

    idle_clks(1000);
    check("idle_active_seen", {31'd0, act_seen}, 0);
    check("idle_byte", {24'd0, rbyte}, 0);

    foreach (vecs[i]) begin
      send_frame(vecs[i], 1'b1, 0);
      idle_clks(2 * CPB);
      drain("good_timeout");
      check("held_byte", {24'd0, rbyte}, {24'd0, vecs[i]});
    end

    act_seen = 1'b0;
    line = 1'b0;
    idle_clks(3);
    line = 1'b1;
    idle_clks(2 * CPB);
    check("glitch_active_seen", {31'd0, act_seen}, 1);
    check("glitch_active_end", {31'd0, act}, 0);
    check("glitch_byte", {24'd0, rbyte}, 32'h80);

    send_frame(8'h3C, 1'b0, 5);
    idle_clks(3 * CPB);
    drain("ferr_timeout");
    check("ferr_byte_kept", {24'd0, rbyte}, 32'h80);
    check("ferr_active_end", {31'd0, act}, 0);

    send_frame(8'h55, 1'b1, 0);
    send_frame(8'hAA, 1'b1, 0);
    send_frame(8'h0F, 1'b1, 0);
    idle_clks(2 * CPB);
    drain("b2b_timeout");
    check("b2b_last_byte", {24'd0, rbyte}, 32'h0F);

    line = 1'b0;
    idle_clks(5 * CPB + CPB / 2);
    rst  = 1'b1;
    line = 1'b1;
    idle_clks(1);
    rst = 1'b0;
    check("midreset_byte", {24'd0, rbyte}, 0);
    check("midreset_active", {31'd0, act}, 0);
    act_seen = 1'b0;
    idle_clks(3 * CPB);
    check("midreset_quiet", {31'd0, act_seen}, 0);
    send_frame(8'h96, 1'b1, 0);
    idle_clks(2 * CPB);
    drain("after_reset_timeout");
    check("after_reset_byte", {24'd0, rbyte}, 32'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
